// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage: datapath widths, fetch FSM
// state encodings and the entry formats held in the fetch FIFO and the
// in-flight RAM pipe.
package cpu_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  // One buffered instruction with the address it was fetched from.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

  // One slot of the in-flight pipe: a RAM read that has been issued.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
  } inflight_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Decode-side valid/ready handshake of the fetch stage. The fetch unit is
// the master (presents instrOut/pcOut/instrValid), decode is the slave.
interface fetch_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0] instrOut;
  logic [PC_W-1:0]    pcOut;
  logic               instrValid;
  logic               instrReady;

  modport master (output instrOut, output pcOut, output instrValid,
                  input  instrReady);
  modport slave  (input  instrOut, input  pcOut, input  instrValid,
                  output instrReady);
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous fetch FIFO with flush, occupancy count and a registered head.
// The head register always holds the oldest entry, so the output is a pure
// flop and stays stable while it is not popped.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  fq_entry_t        wdata_i,
  input  logic             pop_i,
  output fq_entry_t        head_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  fq_entry_t        mem_q [DEPTH];
  fq_entry_t        head_q, head_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next pointers, count and head; a flush empties the queue.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    do_pop = pop_i && (cnt_q != '0);
    rd_d   = do_pop ? ptr_inc(rd_q) : rd_q;
    wr_d   = push_i ? ptr_inc(wr_q) : wr_q;
    cnt_d  = cnt_q + CNT_W'(push_i) - CNT_W'(do_pop);
    head_d = head_q;
    // The word being written becomes the head when nothing else remains.
    if (push_i && ((cnt_q - CNT_W'(do_pop)) == '0)) head_d = wdata_i;
    else if (cnt_d != '0)                           head_d = mem_q[rd_d];
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the count alone decides what is valid.
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = head_q;
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues RAM reads on addrPC, tags each read in a
// RAM_LAT-deep in-flight pipe, captures instrIn at the last stage into the
// fetch FIFO and hands words to decode over the fetch_if handshake.
// Optional build macro FETCH_PERF_EN adds stall/redirect counters.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     FQ_DEPTH = 4,
  parameter int unsigned     RAM_LAT  = 2,
  parameter logic [PC_W-1:0] RESET_PC = 8'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [INSTR_W-1:0] instrIn,
  output logic [PC_W-1:0]    addrPC,
  fetch_if.master            dec,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirectPC,
  input  logic               halt,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        stallCycles,
  output logic [15:0]        redirectCount
`endif
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned CR_W  = $clog2(FQ_DEPTH + RAM_LAT + 1);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  addr_q, addr_d;
  inflight_t        pipe_q [RAM_LAT];
  inflight_t        pipe_d [RAM_LAT];
  logic [CNT_W-1:0] fifo_count;
  logic [CR_W-1:0]  inflight_cnt;
  logic             credit_ok, mode_drop, accept_redirect;
  logic             flush, push, pop;
  fq_entry_t        head;

  assign mode_drop       = !mode && (state_q != FS_IDLE);
  assign accept_redirect = redirect && !mode_drop &&
                           ((state_q == FS_RUN) || (state_q == FS_HALT));
  // Credits ignore a same-cycle pop, so the FIFO can never overflow.
  assign credit_ok = (CR_W'(fifo_count) + inflight_cnt) < CR_W'(FQ_DEPTH);

  // Count reads that are issued but not yet captured.
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RAM_LAT; i++) inflight_cnt = inflight_cnt + CR_W'(pipe_q[i].valid);
  end

  // Fetch FSM: next state, next address, issue and flush decisions.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    flush     = 1'b0;
    pipe_d[0] = '0;
    for (int i = 1; i < RAM_LAT; i++) pipe_d[i] = pipe_q[i-1];
    unique case (state_q)
      FS_IDLE: begin
        flush  = 1'b1;
        addr_d = RESET_PC;
        if (mode) begin
          state_d   = FS_RUN;
          pipe_d[0] = '{valid: 1'b1, pc: RESET_PC};
        end
      end
      FS_RUN: begin
        if (halt) begin
          state_d = FS_HALT;
        end else if (credit_ok) begin
          addr_d    = addr_q + 1'b1;
          pipe_d[0] = '{valid: 1'b1, pc: addr_q + 1'b1};
        end
      end
      FS_HALT: ;
      default: state_d = FS_IDLE;
    endcase
    // A redirect kills every older read and restarts at the target.
    if (accept_redirect) begin
      state_d = FS_RUN;
      flush   = 1'b1;
      addr_d  = redirectPC;
      for (int i = 1; i < RAM_LAT; i++) pipe_d[i] = '0;
      pipe_d[0] = '{valid: 1'b1, pc: redirectPC};
    end
    // Leaving run mode outranks redirect and halt.
    if (mode_drop) begin
      state_d = FS_IDLE;
      flush   = 1'b1;
      addr_d  = RESET_PC;
      for (int i = 0; i < RAM_LAT; i++) pipe_d[i] = '0;
    end
  end

  // State, address and in-flight pipe registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FS_IDLE;
      addr_q  <= RESET_PC;
      for (int i = 0; i < RAM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      for (int i = 0; i < RAM_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign push = pipe_q[RAM_LAT-1].valid && !flush;
  assign pop  = dec.instrValid && dec.instrReady && !flush;

  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ('{pc: pipe_q[RAM_LAT-1].pc, instr: instrIn}),
    .pop_i   (pop),
    .head_o  (head),
    .valid_o (dec.instrValid),
    .count_o (fifo_count)
  );

  assign dec.instrOut = head.instr;
  assign dec.pcOut    = head.pc;
  assign addrPC       = addr_q;
  assign halted       = (state_q == FS_HALT);

`ifdef FETCH_PERF_EN
  logic [15:0] stall_q, redir_q;
  logic        idle_entry;

  assign idle_entry = (state_d == FS_IDLE) && (state_q != FS_IDLE);

  // Saturating stall and redirect counters, cleared on entering IDLE.
  always_ff @(posedge clk) begin
    if (reset || idle_entry) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (dec.instrValid && !dec.instrReady && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (accept_redirect && (redir_q != '1))                  redir_q <= redir_q + 1'b1;
    end
  end

  assign stallCycles   = stall_q;
  assign redirectCount = redir_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a RAM model with one registered read stage
// holding mem[i] = 16'hA000 + i, and hand-computed expected PC/data streams.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic               clk = 1'b0;
  logic               reset, mode, redirect, halt, halted;
  logic [INSTR_W-1:0] instrIn;
  logic [PC_W-1:0]    addrPC, redirectPC;
`ifdef FETCH_PERF_EN
  logic [15:0]        stallCycles, redirectCount;
`endif

  int              total = 0;
  int              bad   = 0;
  logic [PC_W-1:0] exp_pc;

  fetch_if dec_if ();

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .instrIn    (instrIn),
    .addrPC     (addrPC),
    .dec        (dec_if),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .halt       (halt),
    .halted     (halted)
`ifdef FETCH_PERF_EN
    ,
    .stallCycles   (stallCycles),
    .redirectCount (redirectCount)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: registered read of mem[addrPC].
  always @(posedge clk) instrIn <= 16'hA000 + {8'h00, addrPC};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Head must be exp_pc with its RAM word; ready=1 pops it at the next edge.
  task automatic expect_stream(input int n);
    for (int i = 0; i < n; i++) begin
      check("stream_valid", 32'(dec_if.instrValid), 32'd1);
      check("stream_pc", 32'(dec_if.pcOut), 32'(exp_pc));
      check("stream_instr", 32'(dec_if.instrOut), 32'(16'hA000 + {8'h00, exp_pc}));
      exp_pc = exp_pc + 8'd1;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = 1'b0; redirect = 1'b0; halt = 1'b0;
    redirectPC = '0; dec_if.instrReady = 1'b1;
    step(); step();
    check("rst_addr", 32'(addrPC), 32'd0);
    check("rst_valid", 32'(dec_if.instrValid), 32'd0);
    check("rst_instr", 32'(dec_if.instrOut), 32'd0);
    check("rst_pc", 32'(dec_if.pcOut), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    step();
    check("idle_valid", 32'(dec_if.instrValid), 32'd0);

    // Enter run mode: first word three cycles after the mode edge.
    mode = 1'b1;
    step();
    check("start_valid0", 32'(dec_if.instrValid), 32'd0);
    check("start_addr0", 32'(addrPC), 32'd0);
    step();
    check("start_valid1", 32'(dec_if.instrValid), 32'd0);
    step();
    exp_pc = 8'h00;
    expect_stream(6);

    // Back-pressure: head holds, FIFO fills, issue stops at head+3.
    dec_if.instrReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_valid", 32'(dec_if.instrValid), 32'd1);
      check("stall_pc", 32'(dec_if.pcOut), 32'(exp_pc));
      check("stall_instr", 32'(dec_if.instrOut), 32'(16'hA000 + {8'h00, exp_pc}));
    end
    check("stall_addr", 32'(addrPC), 32'(exp_pc + 8'd3));
`ifdef FETCH_PERF_EN
    check("perf_stall", 32'(stallCycles), 32'd10);
`endif
    dec_if.instrReady = 1'b1;
    expect_stream(8);

    // Redirect to 0x80 with three entries queued; the same-cycle pop is dropped.
    dec_if.instrReady = 1'b0;
    step(); step();
    redirect = 1'b1; redirectPC = 8'h80; dec_if.instrReady = 1'b1;
    step();
    redirect = 1'b0;
    check("redir_valid0", 32'(dec_if.instrValid), 32'd0);
    check("redir_addr", 32'(addrPC), 32'h80);
    step();
    check("redir_valid1", 32'(dec_if.instrValid), 32'd0);
    step();
    exp_pc = 8'h80;
    expect_stream(4);

    // Address wrap FE, FF, 00, 01.
    redirect = 1'b1; redirectPC = 8'hFE;
    step();
    redirect = 1'b0;
    check("wrap_valid0", 32'(dec_if.instrValid), 32'd0);
    step(); step();
    exp_pc = 8'hFE;
    expect_stream(4);
`ifdef FETCH_PERF_EN
    check("perf_redir", 32'(redirectCount), 32'd2);
`endif

    // Halt: the head pops, two in-flight words drain, then nothing.
    halt = 1'b1;
    expect_stream(1);
    halt = 1'b0;
    check("halt_halted", 32'(halted), 32'd1);
    expect_stream(2);
    check("halt_empty0", 32'(dec_if.instrValid), 32'd0);
    check("halt_addr", 32'(addrPC), 32'(exp_pc - 8'd1));
    step();
    check("halt_empty1", 32'(dec_if.instrValid), 32'd0);
    check("halt_still", 32'(halted), 32'd1);

    // Redirect out of HALT resumes at 0x10.
    redirect = 1'b1; redirectPC = 8'h10;
    step();
    redirect = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    step(); step();
    exp_pc = 8'h10;
    expect_stream(3);

    // Halt and redirect together: redirect wins, stays in RUN.
    halt = 1'b1; redirect = 1'b1; redirectPC = 8'h40;
    step();
    halt = 1'b0; redirect = 1'b0;
    check("both_halted", 32'(halted), 32'd0);
    check("both_valid", 32'(dec_if.instrValid), 32'd0);
    step(); step();
    exp_pc = 8'h40;
    expect_stream(3);

    // Mode drop mid-stream flushes; re-entry restarts at PC 0.
    mode = 1'b0;
    step();
    check("mdrop_valid", 32'(dec_if.instrValid), 32'd0);
    check("mdrop_addr", 32'(addrPC), 32'd0);
    step();
    check("mdrop_valid1", 32'(dec_if.instrValid), 32'd0);
    mode = 1'b1;
    step(); step(); step();
    exp_pc = 8'h00;
    expect_stream(3);

    // Reset mid-stream discards everything; run mode restarts at PC 0.
    reset = 1'b1;
    step();
    check("mrst_valid", 32'(dec_if.instrValid), 32'd0);
    check("mrst_addr", 32'(addrPC), 32'd0);
    check("mrst_instr", 32'(dec_if.instrOut), 32'd0);
    check("mrst_pc", 32'(dec_if.pcOut), 32'd0);
    reset = 1'b0;
    step();
    check("mrst_valid1", 32'(dec_if.instrValid), 32'd0);
    step(); step();
    exp_pc = 8'h00;
    expect_stream(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
